pipe_stage_buffer: RTL and testbench
====================================

# pipe_stage_buffer

Parametrised, elastic pipeline stage register for the 32-bit MIPS pipeline, replacing the fixed-width, always-load IF/ID, ID/EX, EX/MEM and MEM/WB buffers. Carries a control field and a data field per beat with valid/ready handshaking, a two-entry skid so back-pressure never drops a beat, and a flush that turns the stage into a bubble. One instance sits between each pair of pipeline stages.

## Interface
Parameters:
- CTRL_W, 10, width of control field (WB/M/EX bits); zeroed on bubble/flush
- DATA_W, 128, width of data field (PC+4, operands, immediates, register addresses)
- STAT_W, 16, stall-counter width (only with PIPE_BUF_STATS_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  buffer can accept a beat
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream data field
- flush  in  1  discard all held beats (branch taken / exception)
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts beat
- out_ctrl  out  CTRL_W  control field; all-zero whenever out_valid=0
- out_data  out  DATA_W  data field; undefined whenever out_valid=0
- stall_cnt  out  STAT_W  saturating stall count (only with PIPE_BUF_STATS_EN)

## Operation
- Storage: main register (drives outputs) + skid register.
- States: PB_EMPTY (none held), PB_HALF (main held), PB_FULL (main + skid held).
- in_ready = (state != PB_FULL) && !rst; registered state only, no combinational path from out_ready.
- out_valid = (state != PB_EMPTY).
- Input accept: in_valid && in_ready. Output accept: out_valid && out_ready.
- PB_EMPTY: accept -> main <= in, PB_HALF.
- PB_HALF: accept && out-accept -> main <= in, stay; accept only -> skid <= in, PB_FULL; out-accept only -> PB_EMPTY; neither -> hold.
- PB_FULL: out-accept -> main <= skid, PB_HALF; else hold. No input accepted.
- flush has priority over everything: next state PB_EMPTY, main/skid ctrl cleared to 0, data left as-is; a beat handshaken in the flush cycle is dropped; an output accept in the flush cycle still counts as delivered.
- Ordering strictly FIFO; no beat duplicated or lost except by flush.

## Timing
- Reset (async assert, sync-safe deassert): state PB_EMPTY, out_valid=0, out_ctrl=0, in_ready=0 while rst high and 1 the first cycle after, stall_cnt=0; out_data undefined.
- Latency: beat accepted at edge N is on out_* after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle when out_ready held high.
- Back-pressure: after out_ready drops, at most one more beat accepted (into skid); in_ready low the cycle after entering PB_FULL.
- Recovery: out_ready rising in PB_FULL -> in_ready high next cycle.
- Reset mid-operation: all held beats discarded immediately, same values as reset.

## Configuration
- PIPE_BUF_STATS_EN defined: stall_cnt port present; increments each cycle with out_valid && !out_ready, saturates at 2^STAT_W-1, cleared only by rst (not by flush).
- Undefined: stall_cnt port and counter absent; behaviour otherwise identical.

## Structure
- Package mips_pipe_pkg: enum pipe_buf_state_t {PB_EMPTY, PB_HALF, PB_FULL}; default width constants (PIPE_CTRL_W=10, PIPE_DATA_W=128, PIPE_STAT_W=16); per-stage ctrl field widths (WB=2, M=3, EX=5).
- One sub-module: pipe_sat_counter (parametrised width, enable, async clear, saturating), instantiated only under PIPE_BUF_STATS_EN.

## Test plan
- Reset: rst high mid-stream with main+skid full -> out_valid=0, out_ctrl=0, in_ready=0; after release in_ready=1, stall_cnt=0.
- Streaming: 8 beats data=0..7, ctrl=0x3FF, out_ready=1 -> outputs 0..7 on consecutive cycles, 1-cycle latency, in_ready never low.
- Back-pressure: out_ready=0 while sending beats A,B,C -> A in main, B in skid, in_ready=0 while C held upstream; out_ready=1 -> A,B,C delivered in order, none lost/duplicated.
- Flush in PB_FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, PB_EMPTY; flushed and same-cycle input beats never appear.
- Simultaneous accept in PB_HALF (in_valid=1, out_ready=1) -> stays PB_HALF, main replaced by new beat, in_ready stays 1.
- Stats (PIPE_BUF_STATS_EN, STAT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; flush leaves it 15; rst clears it to 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Shared types and default widths for the MIPS pipeline stage buffers.
//   pipe_buf_state_t : occupancy of a stage buffer (empty / main / main+skid)
//   PIPE_*_W         : default control, data and stall-counter widths
//   PIPE_WB/M/EX_W   : widths of the per-stage control sub-fields
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    PB_EMPTY = 2'd0,  // nothing held
    PB_HALF  = 2'd1,  // main register holds a beat
    PB_FULL  = 2'd2   // main and skid registers both hold a beat
  } pipe_buf_state_t;

  localparam int PIPE_CTRL_W = 10;
  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_STAT_W = 16;

  // Control field split: write-back, memory and execute bits.
  localparam int PIPE_WB_W = 2;
  localparam int PIPE_M_W  = 3;
  localparam int PIPE_EX_W = 5;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
// Saturating up-counter with asynchronous clear.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high clear
//   en    : count this cycle
//   count : current value, sticks at all-ones
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
// Elastic pipeline stage register with a two-entry skid (main + skid).
// Optional feature macro: PIPE_BUF_STATS_EN adds the stall_cnt port and counter.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both high. in_ready depends only on registered state (and rst),
// never on out_ready, so there is no combinational path through the stage.
// out_valid, out_ctrl and out_data are held stable while out_ready is low.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   in_ctrl/in_data     : upstream control and data fields
//   flush               : drop every held beat and any beat entering this cycle
//   out_valid/out_ready : downstream handshake
//   out_ctrl/out_data   : downstream fields (ctrl forced to zero when not valid)
//   buf_state           : debug view of the occupancy state
//   stall_cnt           : saturating stall count (PIPE_BUF_STATS_EN only)
module pipe_stage_buffer
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
`ifdef PIPE_BUF_STATS_EN
  ,
  parameter int STAT_W = PIPE_STAT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output pipe_buf_state_t   buf_state
`ifdef PIPE_BUF_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  pipe_buf_state_t state_q;
  pipe_buf_state_t state_d;

  logic in_acc;
  logic out_acc;
  logic main_from_in;
  logic main_from_skid;
  logic skid_from_in;

  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; flush wins over any handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = PB_EMPTY;
    end else begin
      case (state_q)
        PB_EMPTY: if (in_acc) state_d = PB_HALF;
        PB_HALF: begin
          if (in_acc && !out_acc) state_d = PB_FULL;
          else if (!in_acc && out_acc) state_d = PB_EMPTY;
        end
        PB_FULL: if (out_acc) state_d = PB_HALF;
        default: state_d = PB_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and datapath load decode from registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready       = (state_q != PB_FULL) && !rst;
    out_valid      = (state_q != PB_EMPTY);
    in_acc         = in_valid && in_ready;
    out_acc        = out_valid && out_ready;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (state_q)
      PB_EMPTY: main_from_in = in_acc;
      PB_HALF: begin
        // With both sides moving, the new beat replaces main directly;
        // the skid is only used when the output is blocked.
        if (in_acc && out_acc) main_from_in = 1'b1;
        else if (in_acc) skid_from_in = 1'b1;
      end
      PB_FULL: main_from_skid = out_acc;
      default: ;
    endcase
  end

  // Control fields are cleared on reset and flush so a bubble carries no
  // write-enables or memory strobes into the next stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (main_from_in) main_ctrl <= in_ctrl;
      else if (main_from_skid) main_ctrl <= skid_ctrl;
      if (skid_from_in) skid_ctrl <= in_ctrl;
    end
  end

  // Data needs no reset: it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (main_from_in) main_data <= in_data;
      else if (main_from_skid) main_data <= skid_data;
      if (skid_from_in) skid_data <= in_data;
    end
  end

  // Gating keeps out_ctrl zero after a normal drain, where main_ctrl still
  // holds the last delivered beat.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign buf_state = state_q;

`ifdef PIPE_BUF_STATS_EN
  pipe_sat_counter #(
    .W(STAT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (out_valid && !out_ready),
    .count(stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer
// Bench for pipe_stage_buffer. The reference is a beat queue holding at most
// two entries: the head is what the output must show, ready means fewer than
// two are held, a flush empties it. Stall count is the number of cycles with a
// held head and out_ready low, capped at 2^SW-1.
module tb_pipe_stage_buffer;
  import mips_pipe_pkg::*;

  localparam int CW = 10;
  localparam int DW = 128;
  localparam int SW = 4;
  localparam int BW = CW + DW;
  localparam int STALL_MAX = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b1;
  logic [CW-1:0]   in_ctrl = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic            out_valid;
  logic [CW-1:0]   out_ctrl;
  logic [DW-1:0]   out_data;
  pipe_buf_state_t buf_state;
  logic [SW-1:0]   stall_cnt;

  int checks = 0;
  int failures = 0;

  // Clock / reset
  always #5 clk = ~clk;

  pipe_stage_buffer #(
    .CTRL_W(CW),
    .DATA_W(DW)
`ifdef PIPE_BUF_STATS_EN
    ,
    .STAT_W(SW)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .buf_state(buf_state)
`ifdef PIPE_BUF_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

`ifndef PIPE_BUF_STATS_EN
  assign stall_cnt = '0;
`endif

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard / reference model
  logic [BW-1:0] exp_q[$];
  int stall_m = 0;
  int m_n;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_m = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
`ifdef PIPE_BUF_STATS_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
    end else begin
      m_n = exp_q.size();
      chk("m_out_valid", out_valid, m_n > 0);
      chk("m_in_ready", in_ready, m_n < 2);
      chk("m_state", buf_state, m_n);
      if (m_n > 0) begin
        chk("m_out_ctrl", out_ctrl, exp_q[0][BW-1:DW]);
        chk("m_out_data", out_data, exp_q[0][DW-1:0]);
      end else begin
        chk("m_out_ctrl_idle", out_ctrl, 0);
      end
`ifdef PIPE_BUF_STATS_EN
      chk("m_stall_cnt", stall_cnt, stall_m);
`endif
      // Advance the model to what the next rising edge must produce.
      if (m_n > 0 && !out_ready && stall_m < STALL_MAX) stall_m++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_n > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && m_n < 2) exp_q.push_back({in_ctrl, in_data});
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) step();
    chk("reset_in_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready_after", in_ready, 1);
    step();

    // Streaming: one beat per cycle, one cycle latency
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 10'h3FF, DW'(k));
      step();
      chk("stream_data", out_data, k);
      chk("stream_ctrl", out_ctrl, 10'h3FF);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_state_half", buf_state, PB_HALF);
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_drained", out_valid, 0);

    // Back-pressure: A in main, B in skid, C waits upstream
    out_ready = 1'b0;
    drive(1'b1, 10'h001, 'hA);
    step();
    drive(1'b1, 10'h002, 'hB);
    step();
    chk("bp_state_full", buf_state, PB_FULL);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_a", out_data, 'hA);
    drive(1'b1, 10'h003, 'hC);
    step();
    chk("bp_hold_in_ready", in_ready, 0);
    chk("bp_hold_head_a", out_data, 'hA);
    chk("bp_hold_ctrl_a", out_ctrl, 10'h001);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_data, 'hB);
    chk("bp_recover_ready", in_ready, 1);
    step();
    chk("bp_head_c", out_data, 'hC);
    chk("bp_ctrl_c", out_ctrl, 10'h003);
    drive(1'b0, '0, '0);
    step();
    chk("bp_drained", out_valid, 0);

    // Flush while full with a beat arriving
    out_ready = 1'b0;
    drive(1'b1, 10'h004, 'hD);
    step();
    drive(1'b1, 10'h005, 'hE);
    step();
    drive(1'b1, 10'h006, 'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_state", buf_state, PB_EMPTY);
    out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("flush_no_ghost", out_valid, 0);
    end

`ifdef PIPE_BUF_STATS_EN
    // Stall counter saturation, survives flush, cleared by reset
    out_ready = 1'b0;
    drive(1'b1, 10'h007, 'h5);
    step();
    drive(1'b0, '0, '0);
    repeat (20) step();
    chk("stat_saturate", stall_cnt, 15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stat_after_flush", stall_cnt, 15);
    rst = 1'b1;
    #1;
    chk("stat_after_rst", stall_cnt, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
`endif

    // Reset mid-operation with main and skid occupied
    out_ready = 1'b0;
    drive(1'b1, 10'h008, 'h11);
    step();
    drive(1'b1, 10'h009, 'h22);
    step();
    drive(1'b0, '0, '0);
    chk("midrst_full", buf_state, PB_FULL);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_ctrl", out_ctrl, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_state", buf_state, PB_EMPTY);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", in_ready, 1);
    out_ready = 1'b1;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      if ((i / 100) % 2 == 1) out_ready = ($urandom_range(0, 3) == 0);
      else out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    drive(1'b0, '0, '0);
    flush = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
